// File: rtl/mdu_pkg.sv
// Shared MDU constants: operation encodings, default busy latencies and FSM state type.
package mdu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
   localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
   localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
   localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
   localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
   localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
   localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
   localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // True for the multi-cycle operations that a Start pulse may launch.
   function automatic logic is_long_op(input logic [OP_W-1:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  SrcA,
   input  logic [XLEN-1:0]  SrcB,
   input  logic [OP_W-1:0]  MDUOp,
   input  logic             Start,
   output logic             Busy,
   output logic [XLEN-1:0]  MDURes,
   output logic [XLEN-1:0]  HI,
   output logic [XLEN-1:0]  LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_e       state;
   logic [CNT_W-1:0] count;
   logic             busy_q;
   logic [XLEN-1:0]  hi_q, lo_q;
   logic [XLEN-1:0]  a_q, b_q;
   logic [OP_W-1:0]  op_q;

   logic [2*XLEN-1:0] prod_s, prod_u;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   divisor;
   logic [XLEN-1:0]   quo_s, rem_s, quo_u, rem_u;
   logic              res_we;
   logic [XLEN-1:0]   res_hi, res_lo;

   // Low 64 bits of the product of sign-extended operands is the signed product.
   assign prod_s = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
   assign prod_u = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};

   // Zero and overflow divisors are swapped for 1 so the dividers never see them.
   assign div_zero = (b_q == '0);
   assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
   assign divisor  = (div_zero || div_ovf) ? 32'd1 : b_q;
   assign quo_s    = XLEN'($signed(a_q) / $signed(divisor));
   assign rem_s    = XLEN'($signed(a_q) % $signed(divisor));
   assign quo_u    = a_q / divisor;
   assign rem_u    = a_q % divisor;

   // Result selection for the final RUN edge.
   always_comb begin
      res_we = 1'b1;
      res_hi = hi_q;
      res_lo = lo_q;
      case (op_q)
         MDU_MULT:  {res_hi, res_lo} = prod_s;
         MDU_MULTU: {res_hi, res_lo} = prod_u;
         MDU_DIV: begin
            if (div_zero) begin
               res_we = 1'b0;
            end else if (div_ovf) begin
               res_lo = 32'h8000_0000;
               res_hi = '0;
            end else begin
               res_lo = quo_s;
               res_hi = rem_s;
            end
         end
         MDU_DIVU: begin
            if (div_zero) begin
               res_we = 1'b0;
            end else begin
               res_lo = quo_u;
               res_hi = rem_u;
            end
         end
         default: res_we = 1'b0;
      endcase
   end

   // Control FSM, operand latch, HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= MDU_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start && is_long_op(MDUOp)) begin
                  a_q    <= SrcA;
                  b_q    <= SrcB;
                  op_q   <= MDUOp;
                  count  <= is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else if (!Start) begin
                  if (MDUOp == MDU_MTHI) hi_q <= SrcA;
                  if (MDUOp == MDU_MTLO) lo_q <= SrcA;
               end
            end
            ST_RUN: begin
               if (count == CNT_W'(1)) begin
                  if (res_we) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
                  count  <= '0;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign Busy   = busy_q;
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MDURes = (MDUOp == MDU_MFHI) ? hi_q :
                   (MDUOp == MDU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the mdu block.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] SrcA, SrcB;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] MDURes, HI, LO;

   int checks   = 0;
   int failures = 0;

   mdu dut (
      .clk    (clk),
      .reset  (reset),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .MDUOp  (MDUOp),
      .Start  (Start),
      .Busy   (Busy),
      .MDURes (MDURes),
      .HI     (HI),
      .LO     (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts remaining busy cycles, bounded so a stuck Busy cannot hang the run.
   task automatic wait_idle(output int n);
      n = 0;
      while (Busy && n < 64) begin
         n++;
         step();
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      SrcA  = a;
      SrcB  = b;
      MDUOp = op;
      Start = 1'b1;
      step();
      Start = 1'b0;
      MDUOp = MDU_NONE;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] hi0, lo0;
      int n;
      hi0 = HI;
      lo0 = LO;
      launch(op, a, b);
      check({tag, "_hi_hold"}, HI, hi0);
      check({tag, "_lo_hold"}, LO, lo0);
      wait_idle(n);
      check({tag, "_busy_len"}, 32'(n), 32'(cyc));
      check({tag, "_hi"}, HI, exp_hi);
      check({tag, "_lo"}, LO, exp_lo);
   endtask

   task automatic write_op(input logic [3:0] op, input logic [31:0] a);
      SrcA  = a;
      MDUOp = op;
      step();
      MDUOp = MDU_NONE;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      SrcA  = '0;
      SrcB  = '0;
      MDUOp = MDU_NONE;
      Start = 1'b0;
      step();
      step();
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      reset = 1'b0;
      step();

      run_op("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      write_op(MDU_MTHI, 32'd1);
      write_op(MDU_MTLO, 32'd2);
      check("mthi", HI, 32'd1);
      check("mtlo", LO, 32'd2);
      MDUOp = MDU_MFLO;
      #1;
      check("mflo", MDURes, 32'd2);
      MDUOp = MDU_NONE;
      #1;
      check("mfnone", MDURes, 32'd0);

      run_op("divu0", MDU_DIVU, 32'd7, 32'd0, 10, 32'd1, 32'd2);
      run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
      run_op("divu",  MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);
      run_op("divneg", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

      // Start with a non-launching op, including mthi, must be ignored.
      SrcA  = 32'hDEAD_BEEF;
      MDUOp = MDU_MTHI;
      Start = 1'b1;
      step();
      Start = 1'b0;
      MDUOp = MDU_NONE;
      check("start_mthi_busy", {31'b0, Busy}, 32'd0);
      check("start_mthi_hi", HI, 32'd1);

      // mthi and a second Start during Busy are both ignored.
      launch(MDU_MULT, 32'd3, 32'd4);
      write_op(MDU_MTHI, 32'h1234);
      SrcA  = 32'd7;
      SrcB  = 32'd7;
      MDUOp = MDU_MULT;
      Start = 1'b1;
      step();
      Start = 1'b0;
      MDUOp = MDU_NONE;
      check("busy_mthi_hold", HI, 32'd1);
      wait_idle(n);
      check("b2b_first_len", 32'(n + 2), 32'd5);
      check("b2b_first_hi", HI, 32'd0);
      check("b2b_first_lo", LO, 32'd12);

      // Start in the very cycle Busy has dropped is accepted.
      run_op("b2b_second", MDU_MULTU, 32'd5, 32'd6, 5, 32'd0, 32'd30);

      write_op(MDU_MTHI, 32'h1234);
      MDUOp = MDU_MFHI;
      #1;
      check("mfhi", MDURes, 32'h1234);
      MDUOp = MDU_NONE;

      // Reset in the middle of RUN cycle 3 of a divide.
      launch(MDU_DIV, 32'd100, 32'd7);
      step();
      step();
      check("pre_rst_busy", {31'b0, Busy}, 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, Busy}, 32'd0);
      check("mid_rst_hi", HI, 32'd0);
      check("mid_rst_lo", LO, 32'd0);
      step();
      reset = 1'b0;
      repeat (15) step();
      check("post_rst_busy", {31'b0, Busy}, 32'd0);
      check("post_rst_hi", HI, 32'd0);
      check("post_rst_lo", LO, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
